fft_pkt_source: RTL and testbench

FFT_PKT_SOURCE -- requirements
Module: fft_pkt_source

---
 rtl/fft_pkt_pkg.sv | 20 ++
 rtl/fft_pkt_skid.sv | 61 ++++++
 rtl/fft_pkt_source.sv | 116 +++++++++++
 tb/tb_fft_pkt_source.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkt_pkg.sv
// Shared types and defaults for the FFT packet source/sink blocks.
package fft_pkt_pkg;

  localparam int DATA_W_DEF = 14;
  localparam int LEN_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH
  } state_t;

  // Buffer entry layout; the skid stores it as a flat {data, sop, eop} vector.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic                  sop;
    logic                  eop;
  } entry_t;

endpackage

// File: rtl/fft_pkt_skid.sv
// Two-entry FIFO with registered head; head only moves on pop or when empty.
module fft_pkt_skid #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         empty
);

  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic [1:0]   count_q;
  logic         do_pop;
  logic         do_push;

  assign empty    = (count_q == 2'd0);
  assign full     = (count_q == 2'd2);
  assign do_pop   = pop && !empty;
  // A full buffer still takes a push when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = head_q;

  // Storage and occupancy update.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= push_data;
          else                 tail_q <= push_data;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= push_data;
          end else begin
            head_q <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fft_pkt_source.sv
// Captures ADC samples into framed Avalon-ST packets for the FFT FIFO.
module fft_pkt_source
  import fft_pkt_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [LEN_W-1:0]  num_frames,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic [DATA_W-1:0] src_data,
  output logic              src_valid,
  input  logic              src_ready,
  output logic              src_startofpacket,
  output logic              src_endofpacket,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic              cfg_err
);

  localparam int ENT_W = DATA_W + 2;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, frames_q, idx_q, frm_q;
  logic               overflow_q, cfg_err_q;
  logic               cfg_ok, start_ok, push, pop, accept;
  logic               full, empty, last_sample, last_frame;
  logic [ENT_W-1:0]   push_entry, pop_entry;

  assign cfg_ok      = (frame_len != '0) && (num_frames != '0);
  assign start_ok    = (state_q == ST_IDLE) && start && !abort && cfg_ok;
  assign pop         = src_ready && !empty;
  assign push        = (state_q == ST_RUN) && adc_valid && !abort;
  assign accept      = push && (!full || pop);
  assign last_sample = (idx_q == len_q - 1'b1);
  assign last_frame  = (frm_q == frames_q - 1'b1);
  assign push_entry  = {adc_data, (idx_q == '0), last_sample};

  fft_pkt_skid #(.W(ENT_W)) u_skid (
    .clk       (clk_clk),
    .rst       (reset_reset),
    .clear     (abort),
    .push      (push),
    .push_data (push_entry),
    .full      (full),
    .pop       (pop),
    .pop_data  (pop_entry),
    .empty     (empty)
  );

  assign src_data          = pop_entry[ENT_W-1:2];
  assign src_valid         = !empty;
  assign src_startofpacket = pop_entry[1] && !empty;
  assign src_endofpacket   = pop_entry[0] && !empty;
  assign busy              = (state_q != ST_IDLE);
  assign overflow          = overflow_q;
  assign cfg_err           = cfg_err_q;

  // Next-state decode; abort overrides everything and suppresses done.
  always_comb begin
    state_d = state_q;
    done    = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start && cfg_ok) state_d = ST_RUN;
        ST_RUN:   if (accept && last_sample && last_frame) state_d = ST_FLUSH;
        ST_FLUSH: if (empty) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // State, run configuration, sample/frame counters and status flags.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      frames_q   <= '0;
      idx_q      <= '0;
      frm_q      <= '0;
      overflow_q <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= (state_q == ST_IDLE) && start && !abort && !cfg_ok;
      if (start_ok) begin
        len_q      <= frame_len;
        frames_q   <= num_frames;
        idx_q      <= '0;
        frm_q      <= '0;
        overflow_q <= 1'b0;
      end
      if (accept) begin
        if (last_sample) begin
          idx_q <= '0;
          frm_q <= frm_q + 1'b1;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
      if (push && !accept) overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_pkt_source.sv
// Directed testbench for fft_pkt_source.
module tb_fft_pkt_source;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        start = 1'b0, abort = 1'b0;
  logic [15:0] frame_len = '0, num_frames = '0;
  logic [13:0] adc_data = '0;
  logic        adc_valid = 1'b0;
  logic [13:0] src_data;
  logic        src_valid, src_ready = 1'b0;
  logic        src_startofpacket, src_endofpacket;
  logic        busy, done, overflow, cfg_err;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0, cfg_cnt = 0, busy_cnt = 0;
  logic [13:0] bdata[$];
  logic        bsop[$];
  logic        beop[$];
  logic [13:0] base;
  logic [13:0] expd;

  fft_pkt_source #(.DATA_W(14), .LEN_W(16)) dut (
    .clk_clk           (clk_clk),
    .reset_reset       (reset_reset),
    .start             (start),
    .abort             (abort),
    .frame_len         (frame_len),
    .num_frames        (num_frames),
    .adc_data          (adc_data),
    .adc_valid         (adc_valid),
    .src_data          (src_data),
    .src_valid         (src_valid),
    .src_ready         (src_ready),
    .src_startofpacket (src_startofpacket),
    .src_endofpacket   (src_endofpacket),
    .busy              (busy),
    .done              (done),
    .overflow          (overflow),
    .cfg_err           (cfg_err)
  );

  always #5 clk_clk = ~clk_clk;

  // Beat and pulse monitor, sampled mid-cycle.
  always @(negedge clk_clk) begin
    if (!reset_reset) begin
      if (src_valid && src_ready) begin
        bdata.push_back(src_data);
        bsop.push_back(src_startofpacket);
        beop.push_back(src_endofpacket);
      end
      if (done)    done_cnt++;
      if (cfg_err) cfg_cnt++;
      if (busy)    busy_cnt++;
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_clk);
      #1;
      adc_data = adc_data + 14'd1;
    end
  endtask

  task automatic clear_mon();
    bdata.delete(); bsop.delete(); beop.delete();
    done_cnt = 0; cfg_cnt = 0; busy_cnt = 0;
  endtask

  task automatic pulse_start(input logic [15:0] fl, input logic [15:0] nf);
    frame_len = fl; num_frames = nf;
    start = 1'b1;
    step();
    start = 1'b0;
    base = adc_data;
  endtask

  task automatic test_reset();
    reset_reset = 1'b1;
    step(3);
    n_tests++; if (src_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", src_valid); end
    n_tests++; if (src_data !== 14'd0) begin n_fail++; $display("FAIL reset_data: got %0d want 0", src_data); end
    n_tests++; if ({src_startofpacket, src_endofpacket} !== 2'b00) begin n_fail++; $display("FAIL reset_sop_eop: got %b want 00", {src_startofpacket, src_endofpacket}); end
    n_tests++; if ({busy, done, overflow, cfg_err} !== 4'b0000) begin n_fail++; $display("FAIL reset_status: got %b want 0000", {busy, done, overflow, cfg_err}); end
    reset_reset = 1'b0;
    step(2);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %0b want 0", busy); end
  endtask

  task automatic test_two_frames();
    clear_mon();
    src_ready = 1'b1; adc_valid = 1'b1;
    pulse_start(16'd4, 16'd2);
    step();
    n_tests++; if (src_valid !== 1'b1 || src_data !== base) begin n_fail++; $display("FAIL first_latency: got v=%0b d=%0d want v=1 d=%0d", src_valid, src_data, base); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL run_busy: got %0b want 1", busy); end
    step(20);
    adc_valid = 1'b0;
    n_tests++; if (bdata.size() != 8) begin n_fail++; $display("FAIL two_frames_beats: got %0d want 8", bdata.size()); end
    else begin
      for (int i = 0; i < 8; i++) begin
        expd = base + 14'(i);
        n_tests++; if (bdata[i] !== expd || bsop[i] !== (i == 0 || i == 4) || beop[i] !== (i == 3 || i == 7)) begin
          n_fail++; $display("FAIL two_frames_beat%0d: got d=%0d s=%0b e=%0b want d=%0d s=%0b e=%0b", i, bdata[i], bsop[i], beop[i], expd, (i == 0 || i == 4), (i == 3 || i == 7));
        end
      end
    end
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL two_frames_done: got %0d want 1", done_cnt); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL two_frames_ovf: got %0b want 0", overflow); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL two_frames_idle: got %0b want 0", busy); end
  endtask

  task automatic test_len_one();
    clear_mon();
    src_ready = 1'b1; adc_valid = 1'b1;
    pulse_start(16'd1, 16'd3);
    step(12);
    adc_valid = 1'b0;
    n_tests++; if (bdata.size() != 3) begin n_fail++; $display("FAIL len1_beats: got %0d want 3", bdata.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_tests++; if (bsop[i] !== 1'b1 || beop[i] !== 1'b1) begin n_fail++; $display("FAIL len1_beat%0d: got s=%0b e=%0b want s=1 e=1", i, bsop[i], beop[i]); end
      end
    end
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL len1_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_backpressure();
    clear_mon();
    src_ready = 1'b0; adc_valid = 1'b1;
    pulse_start(16'd16, 16'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      n_tests++; if (src_valid !== 1'b1 || src_data !== base || src_startofpacket !== 1'b1 || src_endofpacket !== 1'b0) begin
        n_fail++; $display("FAIL hold_beat%0d: got v=%0b d=%0d s=%0b e=%0b want v=1 d=%0d s=1 e=0", i, src_valid, src_data, src_startofpacket, src_endofpacket, base);
      end
    end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow: got %0b want 1", overflow); end
    adc_valid = 1'b0; src_ready = 1'b1;
    step(3);
    n_tests++; if (bdata.size() != 2) begin n_fail++; $display("FAIL bp_retained: got %0d want 2", bdata.size()); end
    else begin
      expd = base + 14'd1;
      n_tests++; if (bdata[0] !== base || bdata[1] !== expd) begin n_fail++; $display("FAIL bp_data: got %0d,%0d want %0d,%0d", bdata[0], bdata[1], base, expd); end
    end
    adc_valid = 1'b1;
    step(14);
    adc_valid = 1'b0;
    step(6);
    n_tests++; if (bdata.size() != 16) begin n_fail++; $display("FAIL bp_total: got %0d want 16", bdata.size()); end
    else begin
      n_tests++; if (bsop[2] !== 1'b0 || beop[14] !== 1'b0 || beop[15] !== 1'b1) begin
        n_fail++; $display("FAIL bp_counters: got sop2=%0b eop14=%0b eop15=%0b want 0 0 1", bsop[2], beop[14], beop[15]);
      end
    end
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL bp_sticky: got %0b want 1", overflow); end
  endtask

  task automatic test_cfg_err();
    clear_mon();
    src_ready = 1'b1; adc_valid = 1'b1;
    pulse_start(16'd0, 16'd2);
    step(4);
    adc_valid = 1'b0;
    n_tests++; if (cfg_cnt != 1) begin n_fail++; $display("FAIL cfg_err_pulse: got %0d want 1", cfg_cnt); end
    n_tests++; if (busy_cnt != 0) begin n_fail++; $display("FAIL cfg_err_busy: got %0d cycles want 0", busy_cnt); end
    n_tests++; if (bdata.size() != 0) begin n_fail++; $display("FAIL cfg_err_beats: got %0d want 0", bdata.size()); end
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL cfg_err_ovf_kept: got %0b want 1", overflow); end
  endtask

  task automatic test_abort();
    clear_mon();
    src_ready = 1'b1; adc_valid = 1'b1;
    pulse_start(16'd8, 16'd1);
    step(2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_tests++; if (src_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL abort_next: got v=%0b busy=%0b want 0 0", src_valid, busy); end
    step(3);
    n_tests++; if (done_cnt != 0) begin n_fail++; $display("FAIL abort_done: got %0d want 0", done_cnt); end
    clear_mon();
    start = 1'b1; abort = 1'b1; frame_len = 16'd4; num_frames = 16'd1;
    step();
    start = 1'b0; abort = 1'b0;
    step(3);
    n_tests++; if (busy_cnt != 0 || bdata.size() != 0) begin n_fail++; $display("FAIL start_abort: got busy=%0d beats=%0d want 0 0", busy_cnt, bdata.size()); end
    clear_mon();
    pulse_start(16'd4, 16'd1);
    step(10);
    adc_valid = 1'b0;
    n_tests++; if (bdata.size() != 4) begin n_fail++; $display("FAIL rerun_beats: got %0d want 4", bdata.size()); end
    else begin
      n_tests++; if (bsop[0] !== 1'b1 || beop[3] !== 1'b1 || bdata[0] !== base) begin
        n_fail++; $display("FAIL rerun_frame: got s0=%0b e3=%0b d0=%0d want 1 1 %0d", bsop[0], beop[3], bdata[0], base);
      end
    end
    n_tests++; if (done_cnt != 1) begin n_fail++; $display("FAIL rerun_done: got %0d want 1", done_cnt); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL start_clears_ovf: got %0b want 0", overflow); end
  endtask

  task automatic test_reset_flush();
    clear_mon();
    src_ready = 1'b0; adc_valid = 1'b1;
    pulse_start(16'd2, 16'd1);
    step(2);
    adc_valid = 1'b0;
    n_tests++; if (busy !== 1'b1 || src_valid !== 1'b1) begin n_fail++; $display("FAIL flush_setup: got busy=%0b v=%0b want 1 1", busy, src_valid); end
    reset_reset = 1'b1;
    step();
    n_tests++; if ({src_valid, src_startofpacket, src_endofpacket, busy, done, overflow, cfg_err} !== 7'd0 || src_data !== 14'd0) begin
      n_fail++; $display("FAIL flush_reset: got flags=%b d=%0d want 0000000 d=0", {src_valid, src_startofpacket, src_endofpacket, busy, done, overflow, cfg_err}, src_data);
    end
    reset_reset = 1'b0;
    src_ready = 1'b1;
    clear_mon();
    step(4);
    n_tests++; if (bdata.size() != 0 || busy_cnt != 0) begin n_fail++; $display("FAIL flush_discard: got beats=%0d busy=%0d want 0 0", bdata.size(), busy_cnt); end
  endtask

  initial begin
    test_reset();
    test_two_frames();
    test_len_one();
    test_backpressure();
    test_cfg_err();
    test_abort();
    test_reset_flush();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
